alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_result_sel.sv | 32 +++
 rtl/alu_cmd_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: function codes, FSM states and result-class flags.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  // func[3:2] selects which ALU output bus carries the result
  localparam logic [1:0] CLASS_ARITH = 2'b00;
  localparam logic [1:0] CLASS_LOGIC = 2'b01;
  localparam logic [1:0] CLASS_CMP   = 2'b10;
  localparam logic [1:0] CLASS_SHIFT = 2'b11;

  localparam logic [3:0] FLAG_ARITH = 4'b1000;
  localparam logic [3:0] FLAG_LOGIC = 4'b0100;
  localparam logic [3:0] FLAG_CMP   = 4'b0010;
  localparam logic [3:0] FLAG_SHIFT = 4'b0001;
  localparam logic [3:0] FLAG_NONE  = 4'b0000;

  function automatic logic [3:0] expected_flags(input logic [3:0] func);
    logic [3:0] flags;
    case (func[3:2])
      CLASS_ARITH: flags = FLAG_ARITH;
      CLASS_LOGIC: flags = FLAG_LOGIC;
      CLASS_CMP:   flags = FLAG_CMP;
      default:     flags = FLAG_SHIFT;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/alu_result_sel.sv
// Combinational result selection: picks the ALU bus for the function class, zero-extends it,
// and flags a status mismatch against the class's expected one-hot flag.
module alu_result_sel
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ARITH_WIDTH = 2 * WIDTH,
  parameter int CMP_WIDTH   = 3,
  parameter int SHIFT_WIDTH = WIDTH + 1
) (
  input  logic [3:0]             func,
  input  logic [ARITH_WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0]       logic_out,
  input  logic [CMP_WIDTH-1:0]   cmp_out,
  input  logic [SHIFT_WIDTH-1:0] shift_out,
  input  logic [3:0]             flags,
  output logic [ARITH_WIDTH-1:0] data,
  output logic                   err
);

  always_comb begin
    data = arith_out;
    case (func[3:2])
      CLASS_LOGIC: data = {{(ARITH_WIDTH - WIDTH){1'b0}}, logic_out};
      CLASS_CMP:   data = {{(ARITH_WIDTH - CMP_WIDTH){1'b0}}, cmp_out};
      CLASS_SHIFT: data = {{(ARITH_WIDTH - SHIFT_WIDTH){1'b0}}, shift_out};
      default:     data = arith_out;
    endcase
    err = (flags != expected_flags(func));
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues one command at a time to an external fixed-latency ALU and returns the selected result.
// Optional macro ALU_SEQ_DIV0_CHECK_EN short-circuits divide-by-zero commands to an error response.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ARITH_WIDTH = 2 * WIDTH,
  parameter int CMP_WIDTH   = 3,
  parameter int SHIFT_WIDTH = WIDTH + 1,
  parameter int ALU_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic [3:0]             cmd_func,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [3:0]             alu_func,
  input  logic [ARITH_WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0]       logic_out,
  input  logic [CMP_WIDTH-1:0]   cmp_out,
  input  logic [SHIFT_WIDTH-1:0] shift_out,
  input  logic                   arith_flag,
  input  logic                   logic_flag,
  input  logic                   cmp_flag,
  input  logic                   shift_flag,
  input  logic                   carry_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ARITH_WIDTH-1:0] rsp_data,
  output logic [3:0]             rsp_func,
  output logic [3:0]             rsp_flags,
  output logic                   rsp_carry,
  output logic                   rsp_err
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

  state_t                 state;
  logic [3:0]             count;
  logic [3:0]             alu_flags;
  logic [ARITH_WIDTH-1:0] sel_data;
  logic                   sel_err;
  logic                   div0;

  assign alu_flags = {arith_flag, logic_flag, cmp_flag, shift_flag};

`ifdef ALU_SEQ_DIV0_CHECK_EN
  assign div0 = (cmd_func == FUNC_DIV) && (cmd_b == '0);
`else
  assign div0 = 1'b0;
`endif

  alu_result_sel #(
    .WIDTH       (WIDTH),
    .ARITH_WIDTH (ARITH_WIDTH),
    .CMP_WIDTH   (CMP_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_result_sel (
    .func      (alu_func),
    .arith_out (arith_out),
    .logic_out (logic_out),
    .cmp_out   (cmp_out),
    .shift_out (shift_out),
    .flags     (alu_flags),
    .data      (sel_data),
    .err       (sel_err)
  );

  // cmd_ready is registered so it stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      cmd_ready <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_func  <= '0;
      rsp_flags <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (div0) begin
              rsp_data  <= '0;
              rsp_func  <= cmd_func;
              rsp_flags <= FLAG_NONE;
              rsp_carry <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_a    <= cmd_a;
              alu_b    <= cmd_b;
              alu_func <= cmd_func;
              state    <= DRIVE;
            end
          end
        end
        DRIVE: begin
          count <= LAT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          // The final decrement to zero is the capture cycle
          if (count <= 4'd1) begin
            count     <= '0;
            rsp_data  <= sel_data;
            rsp_func  <= alu_func;
            rsp_flags <= alu_flags;
            rsp_carry <= carry_out;
            rsp_err   <= sel_err;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
